// File: rtl/snail_pkg.sv
// Shared definitions for the snail "01" detector and its downstream monitors:
// FSM state encoding, default window/threshold constants, and a width helper.
package snail_pkg;

    // Burst monitor FSM states, 2-bit encoded.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_ALERT  = 2'd2
    } state_t;

    // Defaults shared with the detector bench.
    localparam int DEF_WINDOW = 8;
    localparam int DEF_THRESH = 3;
    localparam int DEF_CNT_W  = 8;

    // ceil(log2(v)) but never less than one bit, so a counter always exists.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, never wraps.
// reset and clr both clear it and take priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on inc until all-ones; a clearing cycle drops the pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge values of its inputs, independent of statement order.
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/smile_burst_monitor.sv
// Smile burst monitor: consumes the snail detector's pulse (y), opens a
// window anchored at the first smile, and raises a sticky alert when THRESH
// smiles land inside one WINDOW-cycle window. A saturating lifetime smile
// total is kept for status readout. All outputs are registered.
module smile_burst_monitor
    import snail_pkg::*;
#(
    parameter  int WINDOW = DEF_WINDOW,
    parameter  int THRESH = DEF_THRESH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int TMR_W  = clog2_min1(WINDOW),
    localparam int WC_W   = $clog2(THRESH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             y,
    input  logic             clr,
    output logic             alert,
    output logic             busy,
    output logic [WC_W-1:0]  win_count,
    output logic [CNT_W-1:0] smile_total
);

    // The timer is loaded with WINDOW-1 when the window opens. The opening
    // pulse's cycle is the first window cycle, so the window's last cycle is
    // the one where the timer has run down to 1. WINDOW==1 loads 0, which
    // also reads as "last cycle", closing the window on the next cycle.
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
    localparam logic [WC_W-1:0]  WC_THRESH = WC_W'(THRESH);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [WC_W-1:0]  wc_nxt;
    logic             alert_nxt, busy_nxt;
    logic             last_cycle;
    logic             hits_thresh;

    assign last_cycle  = (timer <= TMR_ONE);
    assign hits_thresh = (int'(win_count) + 1 >= THRESH);

    // State register plus the registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-high; it is only seen on a
        // rising clock edge, so no async path into the flops is built.
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            win_count <= '0;
            alert     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            win_count <= wc_nxt;
            alert     <= alert_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state logic: clr beats y; the window is anchored to its first pulse.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_nxt = state;
        timer_nxt = timer;
        wc_nxt    = win_count;

        if (clr) begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
            wc_nxt    = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (y) begin
                        wc_nxt = WC_ONE;
                        if (THRESH == 1) begin
                            state_nxt = ST_ALERT;
                        end else begin
                            state_nxt = ST_WINDOW;
                            timer_nxt = TMR_LOAD;
                        end
                    end
                end
                ST_WINDOW: begin
                    if (y && hits_thresh) begin
                        state_nxt = ST_ALERT;
                        wc_nxt    = WC_THRESH;
                        timer_nxt = '0;
                    end else if (last_cycle) begin
                        // A non-qualifying pulse on the last cycle is dropped
                        // from the window and does not open a new one.
                        state_nxt = ST_IDLE;
                        wc_nxt    = '0;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer - TMR_ONE;
                        wc_nxt    = win_count + WC_W'(y);
                    end
                end
                ST_ALERT: begin
                    wc_nxt = WC_THRESH;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                    wc_nxt    = '0;
                end
            endcase
        end
    end

    // Output decode from the next state, registered with the state.
    always_comb begin
        alert_nxt = (state_nxt == ST_ALERT);
        busy_nxt  = (state_nxt == ST_WINDOW);
    end

    // Lifetime smile total; clr and reset drop a coincident pulse.
    sat_counter #(
        .W (CNT_W)
    ) u_total (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (y),
        .q     (smile_total)
    );

endmodule
